// File: rtl/exc_pkg.sv
// Shared types and cause codes for the exception controller.
package exc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HANDLER,
      HALT
   } state_t;

   localparam logic [3:0] EST_NONE     = 4'b0000;
   localparam logic [3:0] EST_INVOP    = 4'b0001;
   localparam logic [3:0] EST_MISAL    = 4'b0010;
   localparam logic [3:0] EST_IRQ_BASE = 4'b1000;
   localparam logic [3:0] EST_DFAULT   = 4'b1111;

endpackage

// File: rtl/irq_pending_latch.sv
// Rising-edge detector and pending latch for the external IRQ lines.
// A new edge beats a same-cycle clear; freeze holds the pending set unchanged.
module irq_pending_latch #(
   parameter int unsigned NIRQ = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NIRQ-1:0] irq,
   input  logic            freeze,
   input  logic [NIRQ-1:0] clr,
   output logic [NIRQ-1:0] pending
);

   logic [NIRQ-1:0] irq_d;
   logic [NIRQ-1:0] pending_q;
   logic [NIRQ-1:0] pending_d;
   logic [NIRQ-1:0] edges;

   // Next pending set: clear first, then OR in new edges so set wins.
   always_comb begin
      edges     = irq & ~irq_d;
      pending_d = pending_q;
      if (!freeze) begin
         pending_d = (pending_q & ~clr) | edges;
      end
   end

   // Edge history tracks irq every cycle; pending updates per pending_d.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_d     <= '0;
         pending_q <= '0;
      end else begin
         irq_d     <= irq;
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/exception_controller.sv
// Exception request controller: collects faults and IRQs, prioritises them,
// raises one request at a time and halts the core on a fault inside the handler.
module exception_controller
   import exc_pkg::*;
#(
   parameter int unsigned N    = 64,
   parameter int unsigned NIRQ = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NIRQ-1:0] irq,
   input  logic            InvalidOp,
   input  logic [N-1:0]    DM_addr,
   input  logic            DM_access,
   input  logic            ExcAck,
   input  logic            ERet,
   output logic            Exc,
   output logic [3:0]      EStatus,
   output logic            InHandler,
   output logic            Halted,
   output logic [NIRQ-1:0] Pending
);

   // Only the low three address bits decide 8-byte alignment.
   localparam logic [N-1:0] ALIGN_MASK = {{(N-3){1'b0}}, 3'b111};

   state_t     state_q, state_d;
   logic       exc_q, exc_d;
   logic [3:0] estatus_q, estatus_d;
   logic       in_handler_q, in_handler_d;
   logic       halted_q, halted_d;

   logic [NIRQ-1:0] pending;
   logic [NIRQ-1:0] clr;
   logic            freeze;
   logic            misal;
   logic            fault;
   logic [3:0]      fault_cause;
   logic            irq_hit;
   logic [3:0]      irq_cause;

   irq_pending_latch #(
      .NIRQ(NIRQ)
   ) u_irq_pending_latch (
      .clk    (clk),
      .reset  (reset),
      .irq    (irq),
      .freeze (freeze),
      .clr    (clr),
      .pending(pending)
   );

   // Fault detection and fixed-priority IRQ encode (lowest index wins).
   always_comb begin
      misal       = DM_access & (|(DM_addr & ALIGN_MASK));
      fault       = InvalidOp | misal;
      fault_cause = InvalidOp ? EST_INVOP : EST_MISAL;
      irq_hit     = 1'b0;
      irq_cause   = EST_NONE;
      for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
         if (pending[i]) begin
            irq_hit   = 1'b1;
            irq_cause = EST_IRQ_BASE | 4'(i);
         end
      end
   end

   // Retire the serviced IRQ when its request is acknowledged; freeze in HALT.
   always_comb begin
      freeze = (state_q == HALT);
      clr    = '0;
      for (int i = 0; i < int'(NIRQ); i++) begin
         clr[i] = (state_q == REQ) && ExcAck && (estatus_q == (EST_IRQ_BASE | 4'(i)));
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      exc_d        = exc_q;
      estatus_d    = estatus_q;
      in_handler_d = in_handler_q;
      halted_d     = halted_q;
      unique case (state_q)
         IDLE: begin
            if (fault) begin
               estatus_d = fault_cause;
               exc_d     = 1'b1;
               state_d   = REQ;
            end else if (irq_hit) begin
               estatus_d = irq_cause;
               exc_d     = 1'b1;
               state_d   = REQ;
            end
         end
         REQ: begin
            // Cause stays frozen until the datapath takes the exception.
            if (ExcAck) begin
               exc_d        = 1'b0;
               in_handler_d = 1'b1;
               state_d      = HANDLER;
            end
         end
         HANDLER: begin
            // Return takes precedence over a simultaneous fault.
            if (ERet) begin
               estatus_d    = EST_NONE;
               in_handler_d = 1'b0;
               state_d      = IDLE;
            end else if (fault) begin
               estatus_d    = EST_DFAULT;
               halted_d     = 1'b1;
               in_handler_d = 1'b0;
               exc_d        = 1'b0;
               state_d      = HALT;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         exc_q        <= 1'b0;
         estatus_q    <= EST_NONE;
         in_handler_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         exc_q        <= exc_d;
         estatus_q    <= estatus_d;
         in_handler_q <= in_handler_d;
         halted_q     <= halted_d;
      end
   end

   assign Exc       = exc_q;
   assign EStatus   = estatus_q;
   assign InHandler = in_handler_q;
   assign Halted    = halted_q;
   assign Pending   = pending;

endmodule

// File: doc/exception_controller.md
Name: exception_controller

Overview:
- Upstream of the datapath's exception unit. Produces the datapath's Exc and EStatus inputs and consumes its ExcAck and ERet outputs.
- Collects synchronous faults (invalid opcode, misaligned data-memory access) and edge-triggered external IRQs.
- Prioritises the pending events, raises one exception request at a time, and masks further requests until the handler returns.
- Detects a fault inside the handler and halts the core.

Parameters:
N, 64, data-memory address width
NIRQ, 4, number of external IRQ lines (max 4)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
irq  input  NIRQ  external IRQ lines; a rising edge requests service
InvalidOp  input  1  decoder flags the current instruction's opcode as invalid
DM_addr  input  N  data-memory address of the current instruction
DM_access  input  1  current instruction reads or writes data memory (DM_readEnable | DM_writeEnable)
ExcAck  input  1  datapath has taken the exception (PC redirected)
ERet  input  1  handler executed ERET
Exc  output  1  exception request to the datapath
EStatus  output  4  cause code
InHandler  output  1  handler active (requests masked)
Halted  output  1  double fault; core must stop
Pending  output  NIRQ  latched, not-yet-serviced IRQs

Behaviour:
- Reset (synchronous, active-high), priority over every other input:
  - State becomes IDLE.
  - Exc=0, EStatus=0000, InHandler=0, Halted=0, Pending=0.
  - Edge-detect history registers are set to 0.
- Cause codes:
  - 0000 none
  - 0001 invalid opcode
  - 0010 misaligned access
  - 1000+i IRQ i
  - 1111 double fault
- Misaligned access: DM_access=1 and DM_addr[2:0]!=0.
- IRQ edge detection:
  - irq_d registers irq every cycle.
  - An edge is irq & ~irq_d.
  - An edge sets the matching Pending bit in every state except HALT.
  - Pending[i] clears when ExcAck is seen in REQ with EStatus=1000+i.
  - If a new edge on line i arrives in that same cycle, set wins: Pending[i] stays 1.
- Priority, highest first: invalid opcode > misaligned > Pending[0] > Pending[1] > ... > Pending[NIRQ-1].
- State machine: IDLE, REQ, HANDLER, HALT.
- IDLE:
  - If any source is active, the highest-priority cause is latched into EStatus, Exc<=1, next state REQ.
  - Latency from a fault or a Pending bit to Exc is one cycle.
  - A new IRQ edge is registered as Pending first, so Exc follows the edge after two cycles.
  - ExcAck and ERet are ignored.
- REQ:
  - Exc is held at 1 and the cause is frozen; a higher-priority event arriving now does not replace it.
  - Synchronous faults are ignored, because the faulting instruction is being abandoned.
  - On ExcAck: next state HANDLER, Exc<=0, InHandler<=1, EStatus is held so the handler can read it.
  - ERet is ignored.
- HANDLER:
  - IRQ edges accumulate in Pending and are not serviced.
  - On ERet: next state IDLE, EStatus<=0000, InHandler<=0. A still-pending IRQ is requested starting from the following IDLE cycle.
  - On InvalidOp or a misaligned access without ERet: next state HALT, EStatus<=1111, Halted<=1, InHandler<=0, Exc=0.
  - If ERet and a fault occur together, ERet wins.
  - ExcAck is ignored.
- HALT:
  - Absorbing; only reset exits.
  - All inputs are ignored and Pending is frozen.
- Exc is a registered output. There are no combinational paths from inputs to outputs.

Decomposition:
- Package exc_pkg holds:
  - state_t enum {IDLE, REQ, HANDLER, HALT};
  - localparams for the cause codes (EST_NONE, EST_INVOP, EST_MISAL, EST_IRQ_BASE, EST_DFAULT).
- One sub-module, irq_pending_latch: edge detection, Pending set/clear (set wins), freeze input.
- The FSM, priority encoder and misalignment check stay in exception_controller.

Test Plan:
- Reset mid-operation: drive reset=1 for one cycle while in REQ -> next cycle Exc=0, EStatus=0000, Pending=0, state IDLE.
- Invalid opcode in IDLE: InvalidOp=1 at cycle t -> Exc=1, EStatus=0001 at t+1. ExcAck at t+3 -> Exc=0, InHandler=1, EStatus=0001 at t+4. ERet at t+6 -> EStatus=0000, InHandler=0 at t+7.
- Priority: DM_addr=0x1004, DM_access=1 with Pending[2]=1 in IDLE -> EStatus=0010. After ERet, the next IDLE cycle gives Exc=1, EStatus=1010.
- IRQ masking and accumulation: irq[1] edge during HANDLER -> Pending=0010 and Exc stays 0. ERet -> IDLE, then Exc=1, EStatus=1001. ExcAck -> Pending=0000.
- Set-wins boundary: a new irq[0] edge in the same cycle as ExcAck for EStatus=1000 -> Pending[0] remains 1 and is re-requested after ERet.
- Double fault: InvalidOp=1 in HANDLER with ERet=0 -> Halted=1, EStatus=1111, Exc=0. Later irq edges and ERet cause no change until reset. ERet=1 together with InvalidOp=1 -> normal return, Halted=0.
